wb_mem_tester: RTL and testbench
================================

# wb_mem_tester

Wishbone pipelined initiator that writes a pseudo-random 32-bit pattern over a DDR user-port window, reads it back, and counts mismatches. It sits as an extra bus master (or directly on a DDR user port) in the DDR test SoC. It exercises the slave side of the LiteDRAM user ports at full pipelined throughput, which the Ibex core cannot generate. Firmware starts a run and polls the results through the control ports.

## Interface
Parameters:
- AW, 30: word-address width of `wbm_adr`.
- MAX_OUT, 4: maximum number of outstanding (accepted, un-acked) requests, 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE, ignored otherwise.
- base_adr  in  AW  first word address, sampled on accepted `start`.
- num_words  in  24  words to test, sampled on `start`; 0 means an immediate DONE with pass=1.
- seed  in  32  LFSR seed, sampled on `start`; 0 is replaced by 32'h1.
- busy  out  1  high from the cycle after `start` until DONE.
- done  out  1  level, high in DONE until the next accepted `start`.
- pass  out  1  valid when `done`: err_count==0 and bus_err==0.
- bus_err  out  1  a Wishbone `err` was seen during the run.
- err_count  out  24  number of read mismatches, saturating.
- first_err_adr  out  AW  address of the first mismatch; 0 if none.
- wbm_cyc, wbm_stb, wbm_we  out  1  Wishbone master controls.
- wbm_adr  out  AW  word address.
- wbm_dat_m  out  32  write data.
- wbm_sel  out  4  always 4'hF while `stb` is high.
- wbm_dat_s  in  32  read data.
- wbm_ack, wbm_err, wbm_stall  in  1  slave responses.

## Operation
- States: IDLE → WRITE → WDRAIN → GAP → READ → RDRAIN → DONE.
- **Start:** accepted `start` latches the inputs, loads the LFSR, clears the result outputs, and sets `busy`.
- **WRITE:** `cyc`=`stb`=`we`=1.
  - A request is accepted on a cycle with `stb & ~stall`.
  - On accept: `adr` increments, the LFSR advances, the issue count increments.
  - `stb` drops when issue count == num_words or outstanding == MAX_OUT.
  - `stb` is reasserted once outstanding < MAX_OUT.
- **WDRAIN:** `cyc` stays high, `stb` low, until all acks are in. Then `cyc` drops.
- **GAP:** one cycle with `cyc`=0. The LFSR is reloaded with the seed and `adr` with base_adr.
- **READ:** same issue rules as WRITE with `we`=0.
  - A second LFSR, the checker, advances on each `ack` and is compared with `wbm_dat_s`.
  - On mismatch: `err_count` increments, saturating at 24'hFFFFFF.
  - On the first mismatch: `first_err_adr` latches the address of that response. It is tracked by an ack-address counter.
- **RDRAIN:** wait for the remaining acks, then DONE.
- **Bus error:** `wbm_err` in any active state sets `bus_err`, drops `cyc`/`stb` the next cycle, and goes to DONE. No further responses are consumed.
- **Outstanding counter:** +1 on accept, −1 on ack/err. Simultaneous accept and ack leaves it unchanged.
- **Address wrap:** `adr` wraps modulo 2^AW with no error.
- **LFSR:** Galois, 32-bit, polynomial 32'h80200003. next = {1'b0,s[31:1]} ^ (s[0] ? 32'h80200003 : 0). Word 0 uses the seed value itself.
- **Reset mid-run:** all state returns to reset values immediately. No bus cleanup is performed; a slave must tolerate `cyc` dropping.

## Timing
- Reset values:
  - all `wbm_*` outputs 0;
  - busy, done, bus_err = 0;
  - pass = 0;
  - err_count, first_err_adr = 0;
  - state IDLE.
- `start` at cycle T gives `busy`=1 at T+1. The first `stb` is at T+1.
- With zero stall and 1-cycle ack, one word is issued per cycle. N writes take N cycles plus drain.
- `stb`, `adr`, `we`, and `dat_m` are held stable while `stall`=1.
- Acks are expected only while `cyc`=1. Acks beyond the outstanding count are ignored.
- `done`/`pass` are set the cycle after the final ack (or after `err`). `busy` falls on the same cycle.
- `start` while `busy` is ignored.

## Structure
- Package `wb_mem_tester_pkg`:
  - state enum `mt_state_e`;
  - LFSR polynomial constant `MT_LFSR_POLY`;
  - function `mt_lfsr_next`.
- Sub-module `mt_lfsr`: seed load, advance enable, 32-bit output. It is instantiated twice (generator and checker).
- Top: FSM, issue/ack/outstanding counters, result registers.

## Test plan
- Ideal memory model (0 stall, 1-cycle ack), base 0x100, num_words 16, seed 0x1 → 16 writes, then 16 reads of identical data; pass=1, err_count=0; the run is ≤ 40 cycles.
- Model corrupts the word at address 0x105 on read → err_count=1, first_err_adr=0x105, pass=0.
- Random stall (50%) and ack latency 1–6, MAX_OUT=4, num_words 1000 → never more than 4 outstanding, `stb` signals stable under stall, pass=1.
- `err` on the 3rd write ack → bus_err=1, `cyc` low the next cycle, done=1, pass=0, no read phase.
- num_words 0 → done=1 and pass=1 with no `cyc` assertion. seed 0 behaves identically to seed 1.
- Assert rst_n low mid-READ → all outputs are 0 within the same cycle. A following `start` completes normally with pass=1.

Source files
------------

// File: rtl/wb_mem_tester_pkg.sv
// Shared types and LFSR step for the Wishbone memory pattern tester.
// Pure definitions: no state, no timing, no backpressure of its own.
package wb_mem_tester_pkg;

  typedef enum logic [2:0] {
    MT_IDLE,
    MT_WRITE,
    MT_WDRAIN,
    MT_GAP,
    MT_READ,
    MT_RDRAIN,
    MT_DONE
  } mt_state_e;

  localparam logic [31:0] MT_LFSR_POLY = 32'h80200003;
  localparam int          MT_CNT_W     = 24;

  // Galois step: shift right, fold the polynomial in when bit 0 falls out.
  function automatic logic [31:0] mt_lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? MT_LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/mt_lfsr.sv
// 32-bit Galois LFSR; load wins over advance, value visible the cycle after either.
// No backpressure: the owner gates adv_i with its own handshake.
module mt_lfsr
  import wb_mem_tester_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        adv_i,
  output logic [31:0] val_o
);

  logic [31:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = seed_i;
    end else if (adv_i) begin
      val_d = mt_lfsr_next(val_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q <= 32'h1;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/wb_mem_tester.sv
// Pipelined Wishbone initiator: writes an LFSR pattern over a window, reads it back, counts mismatches.
// One request per cycle when unstalled; holds stb/adr/we/dat under stall; caps accepted-unacked requests at MAX_OUT.
module wb_mem_tester
  import wb_mem_tester_pkg::*;
#(
  parameter int AW      = 30,
  parameter int MAX_OUT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_adr,
  input  logic [23:0]   num_words,
  input  logic [31:0]   seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          bus_err,
  output logic [23:0]   err_count,
  output logic [AW-1:0] first_err_adr,
  output logic          wbm_cyc,
  output logic          wbm_stb,
  output logic          wbm_we,
  output logic [AW-1:0] wbm_adr,
  output logic [31:0]   wbm_dat_m,
  output logic [3:0]    wbm_sel,
  input  logic [31:0]   wbm_dat_s,
  input  logic          wbm_ack,
  input  logic          wbm_err,
  input  logic          wbm_stall
);

  localparam int              OW        = 4;
  localparam logic [OW-1:0]   MAX_OUT_C = OW'(MAX_OUT);

  mt_state_e     state_q, state_d;
  logic [AW-1:0] base_q;
  logic [AW-1:0] adr_q, adr_d;
  logic [AW-1:0] ack_adr_q, ack_adr_d;
  logic [AW-1:0] first_err_adr_q, first_err_adr_d;
  logic [23:0]   num_q;
  logic [23:0]   issue_q, issue_d;
  logic [23:0]   err_count_q, err_count_d;
  logic [31:0]   seed_q;
  logic [OW-1:0] out_q, out_d;
  logic          bus_err_q, bus_err_d;
  logic          first_seen_q, first_seen_d;

  logic          start_ok, issuing, cyc, stb, accept;
  logic          rsp_v, rd_ack, mismatch;
  logic [23:0]   issue_nx;
  logic [31:0]   seed_eff;
  logic          gen_load, chk_load;
  logic [31:0]   gen_val, chk_val;

  assign seed_eff = (seed == 32'h0) ? 32'h1 : seed;
  assign start_ok = start && (state_q == MT_IDLE || state_q == MT_DONE);
  assign issuing  = (state_q == MT_WRITE) || (state_q == MT_READ);
  assign cyc      = issuing || (state_q == MT_WDRAIN) || (state_q == MT_RDRAIN);
  assign stb      = issuing && (issue_q != num_q) && (out_q < MAX_OUT_C);
  assign accept   = stb && !wbm_stall;
  assign issue_nx = issue_q + 24'(accept);

  // A response only counts against a request that is actually outstanding.
  assign rsp_v    = cyc && (wbm_ack || wbm_err) && (out_q != '0);
  assign rd_ack   = rsp_v && wbm_ack && !wbm_err &&
                    (state_q == MT_READ || state_q == MT_RDRAIN);
  assign mismatch = rd_ack && (chk_val != wbm_dat_s);

  always_comb begin
    state_d         = state_q;
    adr_d           = adr_q;
    ack_adr_d       = ack_adr_q;
    issue_d         = issue_q;
    err_count_d     = err_count_q;
    first_err_adr_d = first_err_adr_q;
    first_seen_d    = first_seen_q;
    bus_err_d       = bus_err_q;
    out_d           = out_q + OW'(accept) - OW'(rsp_v);
    gen_load        = 1'b0;
    chk_load        = 1'b0;

    if (accept) begin
      adr_d   = adr_q + 1'b1;
      issue_d = issue_nx;
    end
    if (rd_ack) begin
      ack_adr_d = ack_adr_q + 1'b1;
    end
    if (mismatch) begin
      if (err_count_q != 24'hFFFFFF) begin
        err_count_d = err_count_q + 24'd1;
      end
      if (!first_seen_q) begin
        first_err_adr_d = ack_adr_q;
        first_seen_d    = 1'b1;
      end
    end

    case (state_q)
      MT_IDLE, MT_DONE: begin
        if (start_ok) begin
          adr_d           = base_adr;
          ack_adr_d       = base_adr;
          issue_d         = '0;
          out_d           = '0;
          err_count_d     = '0;
          first_err_adr_d = '0;
          first_seen_d    = 1'b0;
          bus_err_d       = 1'b0;
          gen_load        = 1'b1;
          state_d         = (num_words == 24'd0) ? MT_DONE : MT_WRITE;
        end
      end
      MT_WRITE: begin
        if (issue_nx == num_q) state_d = MT_WDRAIN;
      end
      MT_WDRAIN: begin
        if (out_d == '0) state_d = MT_GAP;
      end
      MT_GAP: begin
        adr_d     = base_q;
        ack_adr_d = base_q;
        issue_d   = '0;
        gen_load  = 1'b1;
        chk_load  = 1'b1;
        state_d   = MT_READ;
      end
      MT_READ: begin
        if (issue_nx == num_q) state_d = MT_RDRAIN;
      end
      MT_RDRAIN: begin
        if (out_d == '0) state_d = MT_DONE;
      end
      default: state_d = MT_IDLE;
    endcase

    // A bus error abandons the run; outstanding responses are never consumed.
    if (cyc && wbm_err) begin
      bus_err_d = 1'b1;
      state_d   = MT_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= MT_IDLE;
      base_q          <= '0;
      num_q           <= '0;
      seed_q          <= 32'h1;
      adr_q           <= '0;
      ack_adr_q       <= '0;
      issue_q         <= '0;
      out_q           <= '0;
      err_count_q     <= '0;
      first_err_adr_q <= '0;
      first_seen_q    <= 1'b0;
      bus_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      adr_q           <= adr_d;
      ack_adr_q       <= ack_adr_d;
      issue_q         <= issue_d;
      out_q           <= out_d;
      err_count_q     <= err_count_d;
      first_err_adr_q <= first_err_adr_d;
      first_seen_q    <= first_seen_d;
      bus_err_q       <= bus_err_d;
      if (start_ok) begin
        base_q <= base_adr;
        num_q  <= num_words;
        seed_q <= seed_eff;
      end
    end
  end

  mt_lfsr u_gen (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (gen_load),
    .seed_i (start_ok ? seed_eff : seed_q),
    .adv_i  (accept),
    .val_o  (gen_val)
  );

  mt_lfsr u_chk (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (chk_load),
    .seed_i (seed_q),
    .adv_i  (rd_ack),
    .val_o  (chk_val)
  );

  assign wbm_cyc       = cyc;
  assign wbm_stb       = stb;
  assign wbm_we        = stb && (state_q == MT_WRITE);
  assign wbm_adr       = stb ? adr_q : '0;
  assign wbm_dat_m     = (stb && state_q == MT_WRITE) ? gen_val : 32'h0;
  assign wbm_sel       = stb ? 4'hF : 4'h0;

  assign busy          = (state_q != MT_IDLE) && (state_q != MT_DONE);
  assign done          = (state_q == MT_DONE);
  assign pass          = done && (err_count_q == 24'd0) && !bus_err_q;
  assign bus_err       = bus_err_q;
  assign err_count     = err_count_q;
  assign first_err_adr = first_err_adr_q;

endmodule

// File: tb/tb_wb_mem_tester.sv
// Directed bench for wb_mem_tester against an in-order pipelined memory model.
module tb_wb_mem_tester;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_adr = '0;
  logic [23:0]   num_words = '0;
  logic [31:0]   seed = '0;
  logic          busy, done, pass, bus_err;
  logic [23:0]   err_count;
  logic [AW-1:0] first_err_adr;
  logic          wbm_cyc, wbm_stb, wbm_we;
  logic [AW-1:0] wbm_adr;
  logic [31:0]   wbm_dat_m;
  logic [3:0]    wbm_sel;
  logic [31:0]   wbm_dat_s = '0;
  logic          wbm_ack = 1'b0;
  logic          wbm_err = 1'b0;
  logic          wbm_stall = 1'b0;

  always #5 clk = ~clk;

  wb_mem_tester #(.AW(AW), .MAX_OUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr),
    .num_words(num_words), .seed(seed), .busy(busy), .done(done),
    .pass(pass), .bus_err(bus_err), .err_count(err_count),
    .first_err_adr(first_err_adr), .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb),
    .wbm_we(wbm_we), .wbm_adr(wbm_adr), .wbm_dat_m(wbm_dat_m),
    .wbm_sel(wbm_sel), .wbm_dat_s(wbm_dat_s), .wbm_ack(wbm_ack),
    .wbm_err(wbm_err), .wbm_stall(wbm_stall)
  );

  // ---------------- memory model ----------------
  typedef struct {
    int          due;
    logic [31:0] dat;
    logic        we;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] mem [logic [AW-1:0]];
  int          cyc_n = 0, last_due = 0;
  int          tb_out = 0, max_out = 0, rd_acc = 0, wr_rsp = 0;
  int          mode_rand = 0, corrupt_en = 0, err_target = -1;

  always @(posedge clk) begin
    rsp_t        r;
    logic [31:0] d;
    int          due;
    cyc_n = cyc_n + 1;
    if (!wbm_cyc || !rst_n) begin
      q.delete();
      tb_out = 0;
      wbm_ack <= 1'b0;
      wbm_err <= 1'b0;
    end else begin
      if (wbm_ack || wbm_err) tb_out = tb_out - 1;
      if (wbm_stb && !wbm_stall) begin
        tb_out = tb_out + 1;
        if (tb_out > max_out) max_out = tb_out;
        d = 32'h0;
        if (wbm_we) begin
          mem[wbm_adr] = wbm_dat_m;
        end else begin
          rd_acc = rd_acc + 1;
          if (mem.exists(wbm_adr)) d = mem[wbm_adr];
          if (corrupt_en != 0 && wbm_adr == 30'h105) d = d ^ 32'h1;
        end
        due = cyc_n - 1 + ((mode_rand != 0) ? int'($urandom_range(1, 6)) : 1);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        q.push_back('{due, d, wbm_we});
      end
      wbm_ack <= 1'b0;
      wbm_err <= 1'b0;
      if (q.size() > 0 && q[0].due <= cyc_n) begin
        r = q.pop_front();
        if (r.we) wr_rsp = wr_rsp + 1;
        if (r.we && wr_rsp == err_target) begin
          wbm_err <= 1'b1;
        end else begin
          wbm_ack   <= 1'b1;
          wbm_dat_s <= r.dat;
        end
      end
    end
    wbm_stall <= (mode_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Request signals must not move while the slave stalls them.
  logic          p_hold = 1'b0, p_we = 1'b0;
  logic [AW-1:0] p_adr = '0;
  logic [31:0]   p_dat = '0;
  int            stall_viol = 0, sel_viol = 0;

  always @(negedge clk) begin
    if (rst_n && p_hold &&
        !(wbm_stb && wbm_adr == p_adr && wbm_we == p_we && wbm_dat_m == p_dat))
      stall_viol = stall_viol + 1;
    if (wbm_stb && wbm_sel != 4'hF) sel_viol = sel_viol + 1;
    p_hold = rst_n && wbm_stb && wbm_stall;
    p_adr  = wbm_adr;
    p_we   = wbm_we;
    p_dat  = wbm_dat_m;
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tb_lfsr(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] s, input int idx);
    logic [31:0] v = s;
    for (int i = 0; i < idx; i++) v = tb_lfsr(v);
    return v;
  endfunction

  task automatic do_start(input logic [AW-1:0] b, input logic [23:0] n, input logic [31:0] s);
    @(negedge clk);
    start = 1'b1; base_adr = b; num_words = n; seed = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int first, input int limit, output int cycles);
    cycles = first;
    while (!done && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return {wbm_cyc, wbm_stb, wbm_we, busy, done, pass, bus_err, wbm_sel, 1'b0};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int cyc_cnt, rd0, k;
    logic ok;

    #1;
    check("reset_ctrl", outs_vec(), 64'h0);
    check("reset_adr_dat", {wbm_adr, wbm_dat_m}, 64'h0);
    check("reset_results", {err_count, first_err_adr}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Ideal memory, 16 words from 0x100, seed 1
    rd0 = rd_acc;
    do_start(30'h100, 24'd16, 32'h1);
    check("t1_busy_stb_we", {busy, wbm_stb, wbm_we, wbm_cyc}, 64'hF);
    check("t1_adr0", wbm_adr, 64'h100);
    check("t1_dat0", wbm_dat_m, 64'h1);
    @(negedge clk);
    check("t1_adr1", wbm_adr, 64'h101);
    check("t1_dat1", wbm_dat_m, 64'h80200003);
    wait_done(2, 200, cyc_cnt);
    check("t1_done_pass", {done, pass, busy, bus_err}, 64'hC);
    check("t1_err_count", err_count, 64'h0);
    check("t1_within_40", (cyc_cnt <= 40), 64'h1);
    check("t1_mem102", mem[30'h102], 64'hC0300002);
    check("t1_mem10f", mem[30'h10F], word_at(32'h1, 15));
    check("t1_reads", rd_acc - rd0, 64'd16);

    // Corrupted word at 0x105
    corrupt_en = 1;
    do_start(30'h100, 24'd16, 32'h1);
    wait_done(1, 200, cyc_cnt);
    corrupt_en = 0;
    check("t2_done_pass", {done, pass, bus_err}, 64'h4);
    check("t2_err_count", err_count, 64'h1);
    check("t2_first_err_adr", first_err_adr, 64'h105);

    // Random stall and latency, window wraps past the top of the address space
    mode_rand = 1;
    do_start(30'h3FFFFE00, 24'd1000, 32'hDEADBEEF);
    wait_done(1, 30000, cyc_cnt);
    mode_rand = 0;
    check("t3_done_pass", {done, pass, bus_err}, 64'h6);
    check("t3_err_count", err_count, 64'h0);
    check("t3_max_out_le_4", (max_out <= 4), 64'h1);
    check("t3_stall_stable", stall_viol, 64'h0);
    check("t3_sel", sel_viol, 64'h0);
    check("t3_wrap_mem0", mem[30'h0], word_at(32'hDEADBEEF, 512));
    repeat (3) @(negedge clk);

    // Bus error on the third write response
    rd0 = rd_acc;
    err_target = wr_rsp + 3;
    do_start(30'h200, 24'd16, 32'h5);
    k = 0;
    while (!wbm_err && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t4_err_seen", wbm_err, 64'h1);
    @(negedge clk);
    err_target = -1;
    check("t4_cyc_low", {wbm_cyc, wbm_stb}, 64'h0);
    check("t4_done_flags", {done, pass, bus_err, busy}, 64'hA);
    repeat (5) @(negedge clk);
    check("t4_no_reads", rd_acc - rd0, 64'h0);

    // Zero-length run
    do_start(30'h300, 24'd0, 32'h7);
    check("t5_done_pass", {done, pass, busy, wbm_cyc}, 64'hC);
    @(negedge clk);
    check("t5_cyc_stays_low", {wbm_cyc, done}, 64'h1);

    // Seed 0 behaves as seed 1
    do_start(30'h400, 24'd4, 32'h0);
    check("t6_dat0", wbm_dat_m, 64'h1);
    wait_done(1, 200, cyc_cnt);
    check("t6_pass", {done, pass}, 64'h3);
    check("t6_mem401", mem[30'h401], 64'h80200003);

    // Reset in the middle of the read phase
    do_start(30'h500, 24'd64, 32'h9);
    k = 0;
    ok = 1'b0;
    while (!ok && k < 400) begin
      @(negedge clk);
      ok = wbm_stb && !wbm_we;
      k++;
    end
    check("t7_reached_read", ok, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_ctrl", outs_vec(), 64'h0);
    check("t7_rst_results", {err_count, first_err_adr, wbm_adr}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(30'h600, 24'd8, 32'h3);
    wait_done(1, 200, cyc_cnt);
    check("t7_rerun_pass", {done, pass, bus_err}, 64'h6);
    check("t7_rerun_mem607", mem[30'h607], word_at(32'h3, 7));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
